// File: rtl/poly_recon.sv
// Stage 2 reconstruction: folds a 2N-1 coefficient product into Z_q[x]/(x^N+1) and streams N results.
// Optional RECON_CYCLIC_EN adds cyclic_i to select the x^N-1 fold per frame.
//
// state      | meaning
// COLLECT_LO | accepting c[0..N-1] into the buffer, q sampled on c[0]
// FOLD_HI    | accepting c[N..2N-2], folding each into buf[i-N]
// DRAIN      | streaming buf[0..N-1] downstream, inputs backpressured
module poly_recon #(
  parameter int DEGREE_N  = 16,
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] q_i,
`ifdef RECON_CYCLIC_EN
  input  logic                 cyclic_i,
`endif
  input  logic [BIT_WIDTH-1:0] coeff_i,
  input  logic                 valid_i,
  output logic                 yumi_o,
  output logic [BIT_WIDTH-1:0] coeff_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 done_o
);

  localparam int CW = $clog2(2 * DEGREE_N);
  localparam int OW = $clog2(DEGREE_N);
  localparam logic [CW-1:0] N_CW     = CW'(DEGREE_N);
  localparam logic [CW-1:0] LO_LAST  = CW'(DEGREE_N - 1);
  localparam logic [CW-1:0] HI_LAST  = CW'(2 * DEGREE_N - 2);
  localparam logic [OW-1:0] OUT_LAST = OW'(DEGREE_N - 1);

  typedef enum logic [1:0] {COLLECT_LO, FOLD_HI, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        in_cnt;
  logic [OW-1:0]        out_cnt;
  logic [BIT_WIDTH-1:0] q_reg;
  logic [BIT_WIDTH-1:0] coef_buf [DEGREE_N];
  logic                 accept, xfer, cyclic_sel;
  logic [OW-1:0]        lo_idx, fold_idx;
  logic [BIT_WIDTH:0]   a_ext, c_ext, q_ext, sum_raw;
  logic [BIT_WIDTH-1:0] fold_res;

`ifdef RECON_CYCLIC_EN
  logic cyclic_q;
  assign cyclic_sel = cyclic_q;
`else
  assign cyclic_sel = 1'b0;
`endif

  assign accept = yumi_o;
  assign xfer   = valid_o && ready_i;
  assign lo_idx   = OW'(in_cnt);
  assign fold_idx = OW'(in_cnt - N_CW);

  // Both folds run one bit wider than the coefficient so the wrap correction never overflows.
  always_comb begin
    a_ext   = {1'b0, coef_buf[fold_idx]};
    c_ext   = {1'b0, coeff_i};
    q_ext   = {1'b0, q_reg};
    sum_raw = a_ext + c_ext;
    if (cyclic_sel)
      fold_res = BIT_WIDTH'((sum_raw >= q_ext) ? sum_raw - q_ext : sum_raw);
    else
      fold_res = BIT_WIDTH'((a_ext >= c_ext) ? a_ext - c_ext : a_ext + q_ext - c_ext);
  end

  always_comb begin
    state_d = state_q;
    yumi_o  = 1'b0;
    valid_o = 1'b0;
    coeff_o = '0;
    done_o  = 1'b0;
    case (state_q)
      COLLECT_LO: begin
        yumi_o = valid_i && !rst;
        if (yumi_o && in_cnt == LO_LAST) state_d = FOLD_HI;
      end
      FOLD_HI: begin
        yumi_o = valid_i && !rst;
        if (yumi_o && in_cnt == HI_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        valid_o = 1'b1;
        coeff_o = coef_buf[out_cnt];
        if (ready_i && out_cnt == OUT_LAST) begin
          done_o  = !rst;
          state_d = COLLECT_LO;
        end
      end
      default: state_d = COLLECT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT_LO;
      in_cnt   <= '0;
      out_cnt  <= '0;
      q_reg    <= '0;
`ifdef RECON_CYCLIC_EN
      cyclic_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_cnt <= (in_cnt == HI_LAST) ? '0 : in_cnt + CW'(1);
        if (in_cnt == '0) begin
          q_reg    <= q_i;
`ifdef RECON_CYCLIC_EN
          cyclic_q <= cyclic_i;
`endif
        end
      end
      if (xfer) out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + OW'(1);
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == COLLECT_LO) coef_buf[lo_idx]   <= coeff_i;
      else                       coef_buf[fold_idx] <= fold_res;
    end
  end

endmodule

// File: tb/tb_poly_recon.sv
// Self-checking bench for poly_recon at N=4, W=16: directed frames plus randomized frames
// against an arithmetic ring-fold model. Covers the cyclic mode when RECON_CYCLIC_EN is defined.
module tb_poly_recon;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2 * N - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q_i, coeff_i, coeff_o;
  logic         valid_i, yumi_o, valid_o, ready_i, done_o;
`ifdef RECON_CYCLIC_EN
  logic         cyclic_i;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  int cin   [L];
  int exp_r [N];
  int q_cur;
  bit cyc_cur;

  always #5 clk = ~clk;

  poly_recon #(.DEGREE_N(N), .BIT_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .q_i     (q_i),
`ifdef RECON_CYCLIC_EN
    .cyclic_i(cyclic_i),
`endif
    .coeff_i (coeff_i),
    .valid_i (valid_i),
    .yumi_o  (yumi_o),
    .coeff_o (coeff_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .done_o  (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ring reduction from the definition: r[i] = c[i] -/+ c[i+N] mod q, with c[2N-1] = 0.
  task automatic model;
    for (int i = 0; i < N; i++) begin
      int hi;
      hi = (i + N < L) ? cin[i + N] : 0;
      if (cyc_cur) exp_r[i] = (cin[i] + hi) % q_cur;
      else         exp_r[i] = (((cin[i] - hi) % q_cur) + q_cur) % q_cur;
    end
  endtask

  // bp_mode: 0 ready high, 1 ready low for drain cycles 1..3, 2 random ready.
  task automatic run_frame(input string name, input bit gaps, input int bp_mode);
    int  idx, budget, k, dcyc;
    bit  acc;
    model();
    idx = 0;
    budget = 0;
    while (idx < L && budget < 200) begin
      valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      coeff_i = valid_i ? W'(cin[idx]) : W'($urandom);
      q_i     = (idx == 0) ? W'(q_cur) : W'($urandom);
`ifdef RECON_CYCLIC_EN
      cyclic_i = (idx == 0) ? cyc_cur : 1'($urandom_range(0, 1));
`endif
      ready_i = 1'($urandom_range(0, 1));
      #1;
      check({name, " yumi_collect"}, yumi_o, valid_i);
      check({name, " valid_collect"}, valid_o, 1'b0);
      check({name, " coeff_idle"}, coeff_o, 0);
      check({name, " done_collect"}, done_o, 1'b0);
      acc = yumi_o;
      tick();
      budget++;
      if (acc) idx++;
    end
    if (idx < L) check({name, " collect_timeout"}, idx, L);
    valid_i = 1'b1;
    coeff_i = W'($urandom);
    k = 0;
    dcyc = 0;
    budget = 0;
    while (k < N && budget < 200) begin
      case (bp_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = !(dcyc >= 1 && dcyc <= 3);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      check($sformatf("%s valid_drain%0d", name, dcyc), valid_o, 1'b1);
      check({name, " yumi_drain"}, yumi_o, 1'b0);
      check($sformatf("%s coeff_r%0d", name, k), coeff_o, exp_r[k]);
      check($sformatf("%s done_r%0d", name, k), done_o, ready_i && (k == N - 1));
      if (ready_i) k++;
      tick();
      dcyc++;
      budget++;
    end
    if (k < N) check({name, " drain_timeout"}, k, N);
    check({name, " valid_after"}, valid_o, 1'b0);
    check({name, " done_after"}, done_o, 1'b0);
    check({name, " accept_next"}, yumi_o, 1'b1);
    valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    coeff_i = '0;
    q_i = 17;
    cyc_cur = 1'b0;
`ifdef RECON_CYCLIC_EN
    cyclic_i = 1'b0;
`endif
    tick();
    tick();
    check("reset yumi", yumi_o, 1'b0);
    check("reset valid", valid_o, 1'b0);
    check("reset coeff", coeff_o, 0);
    check("reset done", done_o, 1'b0);
    rst = 1'b0;
    valid_i = 1'b0;
    tick();

    q_cur = 17;
    cin = '{1, 2, 3, 4, 5, 6, 7};
    model();
    check("basic model r0", exp_r[0], 13);
    check("basic model r3", exp_r[3], 4);
    run_frame("basic", 1'b0, 0);

    cin = '{0, 0, 0, 0, 16, 16, 16};
    run_frame("underflow_bp", 1'b0, 1);

    for (int i = 0; i < L; i++) cin[i] = $urandom_range(0, 16);
    run_frame("gap_f1", 1'b1, 2);
    q_cur = 13;
    cin = '{12, 0, 0, 0, 1, 0, 0};
    run_frame("gap_f2_q13", 1'b1, 2);

    q_cur = 17;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      coeff_i = W'(i + 1);
      q_i = 17;
      tick();
    end
    rst = 1'b1;
    #1;
    check("midreset yumi", yumi_o, 1'b0);
    tick();
    rst = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("midreset valid", valid_o, 1'b0);
      check("midreset done", done_o, 1'b0);
      tick();
    end
    cin = '{1, 2, 3, 4, 5, 6, 7};
    run_frame("after_reset", 1'b0, 0);

`ifdef RECON_CYCLIC_EN
    cyc_cur = 1'b1;
    run_frame("cyclic", 1'b0, 0);
    cyc_cur = 1'b0;
    run_frame("cyclic_off", 1'b0, 0);
`endif

    for (int f = 0; f < 20; f++) begin
      q_cur = $urandom_range(2, 65535);
`ifdef RECON_CYCLIC_EN
      cyc_cur = 1'($urandom_range(0, 1));
`endif
      for (int i = 0; i < L; i++) cin[i] = $urandom_range(0, q_cur - 1);
      run_frame($sformatf("rand%0d", f), 1'b1, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
